// File: rtl/pe_gene_collector.sv
// Compacts up to three PE child genes per cycle into a one-gene-per-cycle write stream.
// Optional feature: define GENE_COLLECT_DROP_ZERO_EN to discard all-zero genes at the input.
module pe_gene_collector #(
    parameter int unsigned GENE_SZ = 64,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned ADDR_SZ = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_setup,
    input  logic [ADDR_SZ-1:0] i_base_addr,
    input  logic [GENE_SZ-1:0] i_gene_in1,
    input  logic [GENE_SZ-1:0] i_gene_in2,
    input  logic [GENE_SZ-1:0] i_gene_in3,
    input  logic [2:0]         i_in_valid,
    input  logic               i_genome_end,
    output logic               o_stall,
    output logic               o_wr_valid,
    input  logic               i_wr_ready,
    output logic [GENE_SZ-1:0] o_wr_gene,
    output logic [ADDR_SZ-1:0] o_wr_addr,
    output logic               o_done,
    output logic [ADDR_SZ-1:0] o_gene_count,
    output logic               o_overflow_err
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    typedef enum logic [1:0] {StCollect, StDrain, StDone} state_e;

    state_e             r_state;
    state_e             w_state_next;
    logic [GENE_SZ-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [OCC_W-1:0]   r_occ;
    logic [ADDR_SZ-1:0] r_addr;
    logic [ADDR_SZ-1:0] r_wcnt;
    logic [ADDR_SZ-1:0] r_gcnt;
    logic               r_ovf;

    logic [GENE_SZ-1:0] w_genes [3];
    logic [2:0]         w_vmask;
    logic [OCC_W-1:0]   w_free;
    logic               w_stall;
    logic               w_accept;
    logic               w_pop;
    logic [1:0]         w_npush;
    logic [PTR_W-1:0]   w_off [3];

    assign w_genes[0] = i_gene_in1;
    assign w_genes[1] = i_gene_in2;
    assign w_genes[2] = i_gene_in3;

`ifdef GENE_COLLECT_DROP_ZERO_EN
    assign w_vmask = i_in_valid & {(i_gene_in3 != '0), (i_gene_in2 != '0), (i_gene_in1 != '0)};
`else
    assign w_vmask = i_in_valid;
`endif

    // Draining holds off the next genome's genes until the current one is fully written.
    assign w_free   = OCC_W'(DEPTH) - r_occ;
    assign w_stall  = (w_free < OCC_W'(3)) || (r_state == StDrain);
    assign w_accept = !w_stall && (w_vmask != 3'b000);
    assign w_pop    = (r_occ != '0) && i_wr_ready;
    assign w_npush  = w_accept ? ({1'b0, w_vmask[0]} + {1'b0, w_vmask[1]} + {1'b0, w_vmask[2]})
                               : 2'd0;

    // Each lane lands after the valid lanes below it, so holes are squeezed out.
    assign w_off[0] = '0;
    assign w_off[1] = PTR_W'(w_vmask[0]);
    assign w_off[2] = PTR_W'({1'b0, w_vmask[0]} + {1'b0, w_vmask[1]});

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StCollect: if (i_genome_end) w_state_next = StDrain;
            StDrain: begin
                if ((r_occ == '0) || ((r_occ == OCC_W'(1)) && w_pop)) w_state_next = StDone;
            end
            StDone:    w_state_next = StCollect;
            default:   w_state_next = StCollect;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StCollect;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_occ   <= '0;
            r_addr  <= '0;
            r_wcnt  <= '0;
            r_gcnt  <= '0;
            r_ovf   <= 1'b0;
        end else if (i_setup) begin
            r_state <= StCollect;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_occ   <= '0;
            r_addr  <= i_base_addr;
            r_wcnt  <= '0;
            r_gcnt  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_wptr  <= r_wptr + PTR_W'(w_npush);
            r_occ   <= r_occ + OCC_W'(w_npush) - OCC_W'(w_pop);
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
                r_addr <= r_addr + ADDR_SZ'(1);
            end
            // The FIFO is always empty in StDone, so no pop competes with the clear.
            if (r_state == StDone) begin
                r_gcnt <= r_wcnt;
                r_wcnt <= '0;
            end else if (w_pop) begin
                r_wcnt <= r_wcnt + ADDR_SZ'(1);
            end
            if (w_stall && (w_vmask != 3'b000)) r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst && !i_setup && w_accept) begin
            for (int i = 0; i < 3; i++) begin
                if (w_vmask[i]) r_mem[r_wptr + w_off[i]] <= w_genes[i];
            end
        end
    end

    assign o_stall        = w_stall;
    assign o_wr_valid     = (r_occ != '0);
    assign o_wr_gene      = o_wr_valid ? r_mem[r_rptr] : '0;
    assign o_wr_addr      = r_addr;
    assign o_done         = (r_state == StDone);
    assign o_gene_count   = (r_state == StDone) ? r_wcnt : r_gcnt;
    assign o_overflow_err = r_ovf;
endmodule
